// File: rtl/next_level_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : next_level_mem_if
// Brief    : Request / read-burst / write-burst bundle between a cache's
//            next-level master port and the backing memory.
// Revision : 1.0  initial release
// ============================================================================
interface next_level_mem_if #(
    parameter int WORDW = 32,
    parameter int ADDRW = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [ADDRW-1:0] req_addr;
    logic [WORDW-1:0] rdata;
    logic             rvalid;
    logic             rready;
    logic             rlast;
    logic [WORDW-1:0] wdata;
    logic             wvalid;
    logic             wready;
    logic             done;
    logic             busy;

    modport master (
        output req_valid, req_write, req_addr, rready, wdata, wvalid,
        input  req_ready, rdata, rvalid, rlast, wready, done, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, rready, wdata, wvalid,
        output req_ready, rdata, rvalid, rlast, wready, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/next_level_mem.sv
`default_nettype none
// ============================================================================
// Module   : next_level_mem
// Brief    : Line-granular backing memory; serves fills and writebacks as
//            LINEITEMS-beat bursts after a fixed access latency.
// Revision : 1.0  initial release
// ============================================================================
module next_level_mem #(
    parameter int WORDW     = 32,
    parameter int ADDRW     = 32,
    parameter int LINEITEMS = 64,
    parameter int MEMLINES  = 1024,
    parameter int LATENCY   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    next_level_mem_if.slave   bus
);
    localparam int LB = $clog2(LINEITEMS);
    localparam int IB = $clog2(MEMLINES);
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RBURST = 3'd3;
    localparam logic [2:0] S_WBURST = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    generate
        if (LATENCY < 1) begin : g_latency_check
            $error("next_level_mem: LATENCY must be at least 1");
        end
    endgenerate

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [IB-1:0]    r_idx;
    logic             r_write;
    logic [CW-1:0]    r_cnt;
    logic [LB-1:0]    r_beat;
    logic [WORDW-1:0] r_mem [MEMLINES*LINEITEMS];

    logic             w_accept;
    logic             w_rfire;
    logic             w_wfire;
    logic             w_last_beat;
    logic [IB+LB-1:0] w_maddr;
    logic             w_unused;

    logic             w_req_ready;
    logic [WORDW-1:0] w_rdata;
    logic             w_rvalid;
    logic             w_rlast;
    logic             w_wready;
    logic             w_done;
    logic             w_busy;

    assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
    assign w_rfire     = (r_state == S_RBURST) && bus.rready;
    assign w_wfire     = (r_state == S_WBURST) && bus.wvalid;
    assign w_last_beat = (r_beat == LB'(LINEITEMS - 1));
    assign w_maddr     = {r_idx, r_beat};
    assign w_unused    = ^bus.req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_IDLE;
            S_IDLE:   if (bus.req_valid) w_next = S_WAIT;
            S_WAIT:   if (r_cnt == CW'(1)) w_next = r_write ? S_WBURST : S_RBURST;
            S_RBURST: if (w_rfire && w_last_beat) w_next = S_DONE;
            S_WBURST: if (w_wfire && w_last_beat) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_RESET;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_rdata     = '0;
        w_rvalid    = 1'b0;
        w_rlast     = 1'b0;
        w_wready    = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                w_busy      = 1'b0;
            end
            S_RBURST: begin
                w_rvalid = 1'b1;
                w_rdata  = r_mem[w_maddr];
                w_rlast  = w_last_beat;
            end
            S_WBURST: w_wready = 1'b1;
            S_DONE:   w_done   = 1'b1;
            default:  ;
        endcase
    end

    // Burst always starts at word 0 of the line; r_beat only moves on a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_cnt   <= '0;
            r_beat  <= '0;
        end else begin
            if (w_accept) begin
                r_idx   <= bus.req_addr[LB +: IB];
                r_write <= bus.req_write;
                r_cnt   <= CW'(LATENCY);
                r_beat  <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_rfire || w_wfire) begin
                r_beat <= r_beat + LB'(1);
            end
        end
    end

    // Storage is deliberately not reset so an aborted writeback keeps its beats
    always_ff @(posedge clk) begin
        if (w_wfire) begin
            r_mem[w_maddr] <= bus.wdata;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rdata     = w_rdata;
    assign bus.rvalid    = w_rvalid;
    assign bus.rlast     = w_rlast;
    assign bus.wready    = w_wready;
    assign bus.done      = w_done;
    assign bus.busy      = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_next_level_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_next_level_mem
// Brief    : Scoreboard bench for next_level_mem (LATENCY 4 and LATENCY 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_next_level_mem;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    next_level_mem_if #(.WORDW(32), .ADDRW(32)) m0 ();
    next_level_mem_if #(.WORDW(32), .ADDRW(32)) m1 ();

    next_level_mem #(.WORDW(32), .ADDRW(32), .LINEITEMS(64), .MEMLINES(1024), .LATENCY(4))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(m0));
    next_level_mem #(.WORDW(32), .ADDRW(32), .LINEITEMS(64), .MEMLINES(16), .LATENCY(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model [int];
    logic [32:0] exp_q [$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mget(input int a);
        return model.exists(a) ? model[a] : 32'h0;
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 6) & 32'h3FF);
    endfunction

    // Read-beat monitor: pops the scoreboard on every accepted beat
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && m0.rvalid) begin
            if (stall_prev) chk("rdata_stable", m0.rdata, stall_data);
            if (m0.rready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rbeat", {m0.rlast, m0.rdata}, e);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_data = m0.rdata;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, output int e_cyc);
        @(posedge clk); #1;
        m0.req_valid = 1'b1;
        m0.req_write = wr;
        m0.req_addr  = addr;
        @(negedge clk);
        chk("req_ready", m0.req_ready, 1);
        @(posedge clk); #1;
        e_cyc        = cyc;
        m0.req_valid = 1'b0;
    endtask

    task automatic finish_txn(input string tag);
        @(negedge clk);
        chk({"done_", tag}, m0.done, 1);
        @(negedge clk);
        chk({"done_pulse_", tag}, m0.done, 0);
        chk({"idle_", tag}, m0.req_ready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] pat);
        int e;
        int k     = 0;
        int got   = 0;
        int first = -1;
        int li    = line_of(addr);
        for (int i = 0; i < 64; i++) exp_q.push_back({(i == 63), mget(li * 64 + i)});
        issue(1'b0, addr, e);
        m0.rready = pat[0];
        while (got < 64 && k < 1000) begin
            @(negedge clk);
            if (m0.rvalid && first < 0) begin
                first = cyc - e;
                chk("rlat", first, 4);
            end
            if (m0.rvalid && m0.rready) got++;
            @(posedge clk); #1;
            k++;
            m0.rready = pat[k % 4];
        end
        m0.rready = 1'b0;
        chk("rbeats", got, 64);
        finish_txn("r");
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] base,
                            input logic [3:0] pat, input int stop);
        int e;
        int k     = 0;
        int i     = 0;
        int first = -1;
        int li    = line_of(addr);
        issue(1'b1, addr, e);
        m0.wvalid = pat[0];
        m0.wdata  = base;
        while (i < stop && k < 1000) begin
            @(negedge clk);
            if (m0.wready && first < 0) begin
                first = cyc - e;
                chk("wlat", first, 4);
            end
            if (m0.wready && m0.wvalid) begin
                model[li * 64 + i] = base + 32'(i);
                i++;
            end
            @(posedge clk); #1;
            k++;
            m0.wvalid = pat[k % 4];
            m0.wdata  = pat[k % 4] ? base + 32'(i) : 32'hDEAD_0000 | 32'(k);
        end
        m0.wvalid = 1'b0;
        chk("wbeats", i, stop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int n;
        int got;
        int bad;
        m0.req_valid = 0; m0.req_write = 0; m0.req_addr = 0;
        m0.rready = 0; m0.wdata = 0; m0.wvalid = 0;
        m1.req_valid = 0; m1.req_write = 0; m1.req_addr = 0;
        m1.rready = 0; m1.wdata = 0; m1.wvalid = 0;

        // Reset held three cycles
        repeat (3) @(negedge clk);
        chk("rst_busy", m0.busy, 1);
        chk("rst_req_ready", m0.req_ready, 0);
        chk("rst_done", m0.done, 0);
        chk("rst_rvalid", m0.rvalid, 0);
        chk("rst_wready", m0.wready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready_early", m0.req_ready, 0);
        @(negedge clk);
        chk("rel_req_ready", m0.req_ready, 1);
        chk("rel_busy", m0.busy, 0);

        // Minimum-latency instance: fill of a never-written line
        @(posedge clk); #1;
        m1.req_valid = 1; m1.req_write = 0; m1.req_addr = 32'h0; m1.rready = 1;
        @(posedge clk); #1;
        e = cyc;
        m1.req_valid = 0;
        n = 0;
        @(negedge clk);
        while (!m1.rvalid && n < 50) begin @(negedge clk); n++; end
        chk("rlat_l1", cyc - e, 1);
        got = 0; bad = 0; n = 0;
        while (got < 64 && n < 200) begin
            if (m1.rvalid) begin
                if (m1.rdata !== 32'h0) bad++;
                got++;
                if (got == 64) chk("rlast_l1", m1.rlast, 1);
            end
            @(negedge clk);
            n++;
        end
        chk("rbeats_l1", got, 64);
        chk("rdata_l1_zero_errs", bad, 0);
        chk("done_l1", m1.done, 1);
        m1.rready = 0;

        // Full write then full read
        do_write(32'h0000_0040, 32'hA000_0000, 4'b1111, 64);
        finish_txn("w");
        do_read(32'h0000_0040, 4'b1111);

        // Read backpressure 1,0,0,1
        do_read(32'h0000_0040, 4'b1001);

        // Write with wvalid gaps, then readback
        do_write(32'h0000_00C0, 32'hB000_0000, 4'b1011, 64);
        finish_txn("wgap");
        do_read(32'h0000_00C0, 4'b1111);

        // Offset within line and index aliasing
        do_read(32'h0000_0045, 4'b1111);
        do_read(32'h0001_0040, 4'b1111);

        // Reset after ten beats of a writeback
        do_write(32'h0000_0080, 32'hC000_0000, 4'b1111, 10);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_done", m0.done, 0);
            chk("midrst_busy", m0.busy, 1);
            chk("midrst_req_ready", m0.req_ready, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_done", m0.done, 0);
        @(negedge clk);
        chk("midrst_idle", m0.req_ready, 1);
        do_read(32'h0000_0080, 4'b1111);

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
